// File: rtl/dvp_capture.sv
// DVP camera capture: samples a byte-wide RGB565 camera stream in clk_sys, packs
// pixels to RGB332 frame-buffer writes. Optional colour classifier: DVP_COLOR_CLASS_EN.
module dvp_capture #(
  parameter int H_PIXELS = 160,
  parameter int V_LINES  = 120,
  parameter int ADDR_W   = 15
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              pclk,
  input  logic              href,
  input  logic              vsync,
  input  logic [7:0]        camera_data,
  output logic [7:0]        px_data,
  output logic [ADDR_W-1:0] px_addr,
  output logic              px_we,
  output logic              frame_done,
  output logic              line_err,
  output logic [2:0]        color_code
);

  localparam int COL_W  = $clog2(H_PIXELS + 1);
  localparam int LINE_W = $clog2(V_LINES + 1);
`ifdef DVP_COLOR_CLASS_EN
  localparam int HI_W = 8;
`else
  localparam int HI_W = 6;
`endif

  // state      | meaning
  // WAIT_FRAME | idle until vsync falls; pclk edges ignored
  // FRAME      | inside a frame, between lines; the first href-high pclk edge is the line's high byte
  // BYTE_HI    | in a line, next byte is a pixel's high byte
  // BYTE_LO    | in a line, high byte held, next byte completes the pixel
  typedef enum logic [1:0] {WAIT_FRAME, FRAME, BYTE_HI, BYTE_LO} state_t;

  logic       pclk_s1_q, pclk_s2_q, pclk_s3_q;
  logic       href_s1_q, href_s2_q;
  logic       vsync_s1_q, vsync_s2_q, vsync_s3_q;
  logic [7:0] data_s1_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pclk_s1_q  <= 1'b0;
      pclk_s2_q  <= 1'b0;
      pclk_s3_q  <= 1'b0;
      href_s1_q  <= 1'b0;
      href_s2_q  <= 1'b0;
      vsync_s1_q <= 1'b0;
      vsync_s2_q <= 1'b0;
      vsync_s3_q <= 1'b0;
      data_s1_q  <= 8'h00;
    end else begin
      pclk_s1_q  <= pclk;
      pclk_s2_q  <= pclk_s1_q;
      pclk_s3_q  <= pclk_s2_q;
      href_s1_q  <= href;
      href_s2_q  <= href_s1_q;
      vsync_s1_q <= vsync;
      vsync_s2_q <= vsync_s1_q;
      vsync_s3_q <= vsync_s2_q;
      data_s1_q  <= camera_data;
    end
  end

  logic pclk_rise, vs_rise, vs_fall;
  assign pclk_rise = pclk_s2_q & ~pclk_s3_q;
  assign vs_rise   = vsync_s2_q & ~vsync_s3_q;
  assign vs_fall   = ~vsync_s2_q & vsync_s3_q;

  state_t            state_q, state_d;
  logic              seen_q, seen_d;
  logic [COL_W-1:0]  col_q, col_d;
  logic [LINE_W-1:0] line_q, line_d;
  logic [ADDR_W-1:0] base_q, base_d;
  logic [HI_W-1:0]   hi_q, hi_d, hi_cap;
  logic [7:0]        px_word;
  logic              pix_vld_q, pix_vld_d;
  logic [7:0]        pix_data_q, pix_data_d;
  logic [ADDR_W-1:0] pix_addr_q, pix_addr_d;
  logic [7:0]        px_data_q, px_data_d;
  logic [ADDR_W-1:0] px_addr_q, px_addr_d;
  logic              px_we_q, px_we_d;
  logic              fd_q, fd_d;
  logic              err_q, err_d;
  logic              col_ok, line_ok;

`ifdef DVP_COLOR_CLASS_EN
  assign hi_cap  = data_s1_q;
  assign px_word = {hi_q[7:5], hi_q[2:0], data_s1_q[4:3]};
`else
  assign hi_cap  = {data_s1_q[7:5], data_s1_q[2:0]};
  assign px_word = {hi_q, data_s1_q[4:3]};
`endif

  assign col_ok  = col_q < COL_W'(H_PIXELS);
  assign line_ok = line_q < LINE_W'(V_LINES);

  always_comb begin
    state_d    = state_q;
    seen_d     = seen_q;
    col_d      = col_q;
    line_d     = line_q;
    base_d     = base_q;
    hi_d       = hi_q;
    err_d      = err_q;
    fd_d       = 1'b0;
    pix_vld_d  = 1'b0;
    pix_data_d = pix_data_q;
    pix_addr_d = pix_addr_q;
    px_we_d    = pix_vld_q;
    px_data_d  = pix_vld_q ? pix_data_q : px_data_q;
    px_addr_d  = pix_vld_q ? pix_addr_q : px_addr_q;
    case (state_q)
      WAIT_FRAME: begin
        if (vs_fall) begin
          state_d = FRAME;
          seen_d  = 1'b1;
        end
      end
      FRAME: begin
        if (pclk_rise && href_s2_q) begin
          state_d = BYTE_LO;
          col_d   = '0;
          hi_d    = hi_cap;
        end
      end
      BYTE_HI, BYTE_LO: begin
        if (pclk_rise && href_s2_q) begin
          if (state_q == BYTE_HI) begin
            hi_d    = hi_cap;
            state_d = BYTE_LO;
          end else begin
            state_d = BYTE_HI;
            if (col_ok && line_ok) begin
              pix_vld_d  = 1'b1;
              pix_data_d = px_word;
              pix_addr_d = base_q + ADDR_W'(col_q);
              col_d      = col_q + COL_W'(1);
            end
          end
        end else if (pclk_rise) begin
          // a line ending while the high byte is held leaves that byte orphaned
          state_d = FRAME;
          if (state_q == BYTE_LO) err_d = 1'b1;
          if (line_ok) begin
            line_d = line_q + LINE_W'(1);
            base_d = base_q + ADDR_W'(H_PIXELS);
          end
        end
      end
      default: state_d = WAIT_FRAME;
    endcase
    if (state_q != WAIT_FRAME && vs_rise) begin
      state_d = WAIT_FRAME;
      fd_d    = seen_q;
      seen_d  = 1'b0;
      col_d   = '0;
      line_d  = '0;
      base_d  = '0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= WAIT_FRAME;
      seen_q     <= 1'b0;
      col_q      <= '0;
      line_q     <= '0;
      base_q     <= '0;
      hi_q       <= '0;
      err_q      <= 1'b0;
      fd_q       <= 1'b0;
      pix_vld_q  <= 1'b0;
      pix_data_q <= 8'h00;
      pix_addr_q <= '0;
      px_we_q    <= 1'b0;
      px_data_q  <= 8'h00;
      px_addr_q  <= '0;
    end else begin
      state_q    <= state_d;
      seen_q     <= seen_d;
      col_q      <= col_d;
      line_q     <= line_d;
      base_q     <= base_d;
      hi_q       <= hi_d;
      err_q      <= err_d;
      fd_q       <= fd_d;
      pix_vld_q  <= pix_vld_d;
      pix_data_q <= pix_data_d;
      pix_addr_q <= pix_addr_d;
      px_we_q    <= px_we_d;
      px_data_q  <= px_data_d;
      px_addr_q  <= px_addr_d;
    end
  end

  assign px_data    = px_data_q;
  assign px_addr    = px_addr_q;
  assign px_we      = px_we_q;
  assign frame_done = fd_q;
  assign line_err   = err_q;

`ifdef DVP_COLOR_CLASS_EN
  logic [4:0]        r5, g5, b5;
  logic [2:0]        cls_q, cls_d, color_q, color_d;
  logic [ADDR_W-1:0] red_q, red_d, grn_q, grn_d, blu_q, blu_d;

  // green is compared on its top five bits so all three channels share a scale
  always_comb begin
    r5      = hi_q[7:3];
    g5      = {hi_q[2:0], data_s1_q[7:6]};
    b5      = data_s1_q[4:0];
    cls_d   = cls_q;
    red_d   = red_q;
    grn_d   = grn_q;
    blu_d   = blu_q;
    color_d = color_q;
    if (pix_vld_d) begin
      cls_d = {(r5 > g5) && (r5 > b5), (g5 > r5) && (g5 > b5), (b5 > r5) && (b5 > g5)};
    end
    if (pix_vld_q) begin
      if (cls_q[2] && red_q != '1) red_d = red_q + ADDR_W'(1);
      if (cls_q[1] && grn_q != '1) grn_d = grn_q + ADDR_W'(1);
      if (cls_q[0] && blu_q != '1) blu_d = blu_q + ADDR_W'(1);
    end
    if (fd_d) begin
      if (red_q > grn_q && red_q > blu_q)      color_d = 3'b100;
      else if (grn_q > red_q && grn_q > blu_q) color_d = 3'b010;
      else if (blu_q > red_q && blu_q > grn_q) color_d = 3'b001;
      else                                     color_d = 3'b000;
      red_d = '0;
      grn_d = '0;
      blu_d = '0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cls_q   <= 3'b000;
      color_q <= 3'b000;
      red_q   <= '0;
      grn_q   <= '0;
      blu_q   <= '0;
    end else begin
      cls_q   <= cls_d;
      color_q <= color_d;
      red_q   <= red_d;
      grn_q   <= grn_d;
      blu_q   <= blu_d;
    end
  end

  assign color_code = color_q;
`else
  assign color_code = 3'b000;
`endif

endmodule

// File: tb/tb_dvp_capture.sv
// Directed bench for dvp_capture: scoreboard of expected frame-buffer writes,
// frame_done / line_err / color_code checks and a reset-mid-line scenario.
module tb_dvp_capture;
  localparam int H  = 160;
  localparam int V  = 4;
  localparam int AW = 15;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          pclk = 1'b0;
  logic          href = 1'b0;
  logic          vsync = 1'b1;
  logic [7:0]    camera_data = 8'h00;
  logic [7:0]    px_data;
  logic [AW-1:0] px_addr;
  logic          px_we;
  logic          frame_done;
  logic          line_err;
  logic [2:0]    color_code;

  dvp_capture #(.H_PIXELS(H), .V_LINES(V), .ADDR_W(AW)) dut (
    .clk(clk), .reset(rst_n), .pclk(pclk), .href(href), .vsync(vsync),
    .camera_data(camera_data), .px_data(px_data), .px_addr(px_addr),
    .px_we(px_we), .frame_done(frame_done), .line_err(line_err),
    .color_code(color_code)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [7:0]    data;
  } px_t;

  px_t           sb[$];
  px_t           mon_e;
  int            total = 0;
  int            bad = 0;
  int            we_cnt = 0;
  int            fd_cnt = 0;
  int            we0 = 0;
  int            fd0 = 0;
  int            line_m = 0;
  int            col_m = 0;
  logic [AW-1:0] last_addr = '0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] px332(input logic [15:0] p);
    return {p[15:13], p[10:8], p[4:3]};
  endfunction

  function automatic logic [2:0] cc(input logic [2:0] c);
`ifdef DVP_COLOR_CLASS_EN
    return c;
`else
    return 3'b000 & c;
`endif
  endfunction

  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      if (px_we === 1'b1) begin
        we_cnt++;
        last_addr = px_addr;
        total++;
        assert (sb.size() != 0) else begin
          bad++;
          $error("FAIL px_we_unexpected: observed write addr=0x%0h expected no write", px_addr);
        end
        if (sb.size() != 0) begin
          mon_e = sb.pop_front();
          chk("px_addr", 32'(px_addr), 32'(mon_e.addr));
          chk("px_data", 32'(px_data), 32'(mon_e.data));
        end
      end
      if (frame_done === 1'b1) fd_cnt++;
    end
  end

  task automatic send_byte(input logic [7:0] b, input logic h);
    @(negedge clk);
    camera_data = b;
    href = h;
    pclk = 1'b0;
    repeat (4) @(negedge clk);
    pclk = 1'b1;
    repeat (4) @(negedge clk);
  endtask

  task automatic push_px(input logic [15:0] p);
    px_t e;
    if (col_m < H && line_m < V) begin
      e.addr = AW'(line_m * H + col_m);
      e.data = px332(p);
      sb.push_back(e);
    end
    col_m++;
  endtask

  task automatic send_pixel(input logic [15:0] p);
    push_px(p);
    send_byte(p[15:8], 1'b1);
    send_byte(p[7:0], 1'b1);
  endtask

  task automatic end_line();
    send_byte(8'h00, 1'b0);
    if (line_m < V) line_m++;
    send_byte(8'h00, 1'b0);
  endtask

  task automatic send_line(input int npix, input logic [15:0] p0, input logic [15:0] p1);
    col_m = 0;
    for (int i = 0; i < npix; i++) send_pixel((i % 2) ? p1 : p0);
    end_line();
  endtask

  task automatic frame_begin();
    vsync = 1'b1;
    repeat (4) @(negedge clk);
    vsync = 1'b0;
    repeat (6) @(negedge clk);
    line_m = 0;
    col_m = 0;
    we0 = we_cnt;
    fd0 = fd_cnt;
  endtask

  task automatic frame_end(input string tag, input int exp_we, input logic [2:0] exp_cc);
    vsync = 1'b1;
    repeat (8) @(negedge clk);
    chk({tag, "_we_count"}, 32'(we_cnt - we0), 32'(exp_we));
    chk({tag, "_frame_done"}, 32'(fd_cnt - fd0), 32'd1);
    chk({tag, "_color_code"}, 32'(color_code), 32'(cc(exp_cc)));
    chk({tag, "_sb_drained"}, 32'(sb.size()), 32'd0);
  endtask

  initial begin
    #20;
    chk("rst_px_we", 32'(px_we), 32'd0);
    chk("rst_px_data", 32'(px_data), 32'd0);
    chk("rst_px_addr", 32'(px_addr), 32'd0);
    chk("rst_frame_done", 32'(frame_done), 32'd0);
    chk("rst_line_err", 32'(line_err), 32'd0);
    chk("rst_color_code", 32'(color_code), 32'd0);
    #80;
    rst_n = 1'b1;

    // bytes while waiting for a frame must be ignored
    for (int i = 0; i < 4; i++) send_byte(8'hF8, 1'b1);
    send_byte(8'h00, 1'b0);
    chk("idle_no_frame_done", 32'(fd_cnt), 32'd0);

    // frame A: all red, one over-long line, one line beyond V_LINES
    frame_begin();
    send_line(160, 16'hF800, 16'hF800);
    chk("line0_we_count", 32'(we_cnt - we0), 32'd160);
    chk("line0_last_addr", 32'(last_addr), 32'd159);
    send_line(200, 16'hF800, 16'hF800);
    chk("long_line_we_count", 32'(we_cnt - we0), 32'd320);
    chk("long_line_last_addr", 32'(last_addr), 32'd319);
    send_line(160, 16'hF800, 16'hF800);
    send_line(160, 16'hF800, 16'hF800);
    send_line(160, 16'hF800, 16'hF800);
    frame_end("frameA", 640, 3'b100);
    chk("frameA_last_addr", 32'(last_addr), 32'(H * V - 1));

    // frame B: green/blue alternating, equal counts
    frame_begin();
    for (int l = 0; l < 4; l++) send_line(20, 16'h07E0, 16'h001F);
    frame_end("frameB", 80, 3'b000);

    // frame C: blue majority
    frame_begin();
    send_line(8, 16'h001F, 16'h001F);
    send_line(2, 16'h07E0, 16'h07E0);
    frame_end("frameC", 10, 3'b001);

    // frame D: odd-length line, write latency check on the completing byte
    chk("line_err_before", 32'(line_err), 32'd0);
    frame_begin();
    push_px(16'hF800);
    send_byte(8'hF8, 1'b1);
    @(negedge clk);
    camera_data = 8'h00;
    href = 1'b1;
    pclk = 1'b0;
    repeat (4) @(negedge clk);
    pclk = 1'b1;
    repeat (3) @(negedge clk);
    chk("we_latency_early", 32'(px_we), 32'd0);
    @(negedge clk);
    chk("we_latency_exact", 32'(px_we), 32'd1);
    send_byte(8'hF8, 1'b1);
    end_line();
    chk("line_err_set", 32'(line_err), 32'd1);
    send_line(2, 16'hF800, 16'hF800);
    chk("after_err_last_addr", 32'(last_addr), 32'(H + 1));
    frame_end("frameD", 3, 3'b100);

    // frame E: green majority; line_err must still be held
    frame_begin();
    send_line(6, 16'h07E0, 16'h07E0);
    frame_end("frameE", 6, 3'b010);
    chk("line_err_sticky", 32'(line_err), 32'd1);

    // reset in the middle of line 0 after 50 pixels
    frame_begin();
    col_m = 0;
    for (int i = 0; i < 50; i++) send_pixel(16'hF800);
    send_byte(8'hF8, 1'b1);
    chk("pre_reset_sb_drained", 32'(sb.size()), 32'd0);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("midrst_px_we", 32'(px_we), 32'd0);
    chk("midrst_px_data", 32'(px_data), 32'd0);
    chk("midrst_px_addr", 32'(px_addr), 32'd0);
    chk("midrst_frame_done", 32'(frame_done), 32'd0);
    chk("midrst_line_err", 32'(line_err), 32'd0);
    chk("midrst_color_code", 32'(color_code), 32'd0);
    repeat (10) @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 21; i++) send_byte((i % 2) ? 8'h00 : 8'hF8, 1'b1);
    send_byte(8'h00, 1'b0);
    chk("post_reset_no_we", 32'(we_cnt - we0), 32'd50);
    vsync = 1'b1;
    repeat (8) @(negedge clk);
    chk("post_reset_no_frame_done", 32'(fd_cnt - fd0), 32'd0);
    frame_begin();
    send_line(8, 16'hF800, 16'hF800);
    chk("restart_last_addr", 32'(last_addr), 32'd7);
    frame_end("frameR", 8, 3'b100);
    chk("restart_line_err", 32'(line_err), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
